// File: rtl/main_memory_responder.sv
// Main-memory model for the cache/memory bus: accepts one MStrobe request at a time,
// waits WAIT_CYCLES clocks, performs the word access and pulses MRdy for one cycle.
module main_memory_responder #(
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = 32,
    parameter int DEPTH       = 256,
    parameter int WAIT_CYCLES = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              MStrobe,
    input  logic              MRW,
    input  logic [ADDR_W-1:0] MAddr,
    input  logic [DATA_W-1:0] MDataIn,
    output logic [DATA_W-1:0] MDataOut,
    output logic              MRdy,
    output logic              MBusy
);

    localparam int               IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0]       CNT_INIT = 4'(WAIT_CYCLES - 1);
    localparam logic [ADDR_W:0]  DEPTH_L  = (ADDR_W + 1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DONE
    } state_t;

    state_t            state_reg, state_next;
    logic [3:0]        cnt_reg, cnt_next;
    logic              rw_reg, rw_next;
    logic [ADDR_W-1:0] addr_reg, addr_next;
    logic [DATA_W-1:0] data_reg, data_next;
    logic [DATA_W-1:0] dout_reg;
    logic              rdy_reg;
    logic              busy_reg;
    logic              access;
    logic              in_range;
    logic [IDX_W-1:0]  mem_idx;

    logic [DATA_W-1:0] mem [DEPTH];

    assign in_range = ({1'b0, addr_reg} < DEPTH_L);
    assign mem_idx  = addr_reg[IDX_W-1:0];

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        rw_next    = rw_reg;
        addr_next  = addr_reg;
        data_next  = data_reg;
        access     = 1'b0;
        case (state_reg)
            IDLE: begin
                if (MStrobe) begin
                    rw_next    = MRW;
                    addr_next  = MAddr;
                    data_next  = MDataIn;
                    cnt_next   = CNT_INIT;
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (cnt_reg == 4'd0) begin
                    access     = 1'b1;
                    state_next = DONE;
                end else begin
                    cnt_next = cnt_reg - 4'd1;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Status outputs are registered from the next state so they line up with it.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
            cnt_reg   <= 4'd0;
            rw_reg    <= 1'b0;
            addr_reg  <= '0;
            data_reg  <= '0;
            rdy_reg   <= 1'b0;
            busy_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            rw_reg    <= rw_next;
            addr_reg  <= addr_next;
            data_reg  <= data_next;
            rdy_reg   <= (state_next == DONE);
            busy_reg  <= (state_next != IDLE);
        end
    end

    // Array has no reset; a commit coinciding with reset is suppressed.
    always_ff @(posedge clk) begin
        if (access && !rw_reg && in_range && !reset) begin
            mem[mem_idx] <= data_reg;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            dout_reg <= '0;
        end else if (access && rw_reg) begin
            dout_reg <= in_range ? mem[mem_idx] : '0;
        end
    end

    assign MDataOut = dout_reg;
    assign MRdy     = rdy_reg;
    assign MBusy    = busy_reg;

endmodule

// File: doc/main_memory_responder.md
# main_memory_responder

Main-memory side of the cache/memory bus: answers the cache controller's MStrobe/MRW requests with a fixed, parameterised wait-state latency. Holds a single-port word array and latches each request's address, direction and write data. On completion it performs the access and pulses MRdy for one cycle, which the controller uses to end its memory wait. It sits below the cache controller FSM, in place of a real DRAM.

## Interface
Parameters:
- ADDR_W, 8, word-address width
- DATA_W, 32, data word width
- DEPTH, 256, number of words (≤ 2^ADDR_W)
- WAIT_CYCLES, 4, access latency in clocks, legal range 1..15

Ports:
- clk  input  1  single clock, all logic on rising edge
- reset  input  1  synchronous, active-high
- MStrobe  input  1  request valid from cache controller
- MRW  input  1  1 = read, 0 = write; sampled with MStrobe
- MAddr  input  ADDR_W  word address; sampled with MStrobe
- MDataIn  input  DATA_W  write data; sampled with MStrobe
- MDataOut  output  DATA_W  read data
- MRdy  output  1  one-cycle completion pulse
- MBusy  output  1  high whenever a request is in flight (state ≠ IDLE)

## Operation
- Clock and reset: one clock; reset is synchronous and active-high.
- FSM states: IDLE, WAIT, DONE. Counter cnt has 4 bits.
- IDLE: if MStrobe=1, latch MRW, MAddr and MDataIn, set cnt = WAIT_CYCLES−1, and go to WAIT. Otherwise stay in IDLE.
- WAIT: if cnt=0, perform the access and go to DONE. Otherwise decrement cnt.
  - Write: mem[addr_q] ← data_q.
  - Read: MDataOut ← mem[addr_q].
- DONE: MRdy=1 for this single cycle, then return to IDLE unconditionally.
- MStrobe is sampled only in IDLE. Strobes in WAIT or DONE are ignored; no queueing.
- Once a request is accepted, MAddr, MDataIn and MRW may change freely; only the latched copies are used.
- An address ≥ DEPTH completes normally with the same latency:
  - a write is dropped;
  - a read returns all zeros.
- MDataOut changes only when a read completes. It holds its value across writes and idle cycles.
- The memory array is not cleared by reset. Its contents are undefined until written.

## Timing
- Reset values (at the first edge with reset=1):
  - state=IDLE, cnt=0
  - MRdy=0, MBusy=0, MDataOut=0
- Reset mid-request: the in-flight request is abandoned and no MRdy is issued.
  - A write whose commit edge coincides with reset is not performed.
  - Earlier committed array contents are preserved.
- Latency: MStrobe is sampled high in IDLE at edge k.
  - MBusy is high from edge k through edge k+WAIT_CYCLES+1.
  - The array write or MDataOut update occurs at edge k+WAIT_CYCLES.
  - MRdy is high for exactly the cycle between edge k+WAIT_CYCLES and edge k+WAIT_CYCLES+1.
- The earliest next accept is at edge k+WAIT_CYCLES+2, i.e. the first IDLE cycle. Minimum request spacing is WAIT_CYCLES+2 clocks.
- With WAIT_CYCLES=1, the FSM spends exactly one cycle in WAIT.
- MDataOut is valid in the MRdy cycle and stays stable until the next read completes.
- Outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- Reset check: hold reset for 2 cycles with MStrobe=1. Required: MRdy=0, MBusy=0 and MDataOut=0 throughout; after release, the first accept occurs on the next edge with MStrobe=1.
- Write then read (WAIT_CYCLES=4):
  - Write 0xDEADBEEF to address 0x10 at edge 0. Required: MRdy high only in cycle 4→5; MBusy high for edges 0..5.
  - Read address 0x10 at edge 6. Required: MDataOut=0xDEADBEEF with MRdy in cycle 10→11.
- Ignored strobe: issue a read of address 0x10, then pulse MStrobe with MRW=0, MAddr=0x10, MDataIn=0x0 while in WAIT. Required: a single MRdy; address 0x10 still reads back 0xDEADBEEF.
- Input change after accept: accept a write to 0x20 with data 0x12345678, then change MAddr to 0x21 and MDataIn to 0xFFFFFFFF during WAIT. Required: address 0x20 reads 0x12345678.
- Reset mid-read: accept a read of address 0x10, then assert reset at edge k+2. Required: no MRdy, MDataOut=0, and a later read of 0x10 returns 0xDEADBEEF.
- Out of range and minimum latency (DEPTH=128, WAIT_CYCLES=1): write 0xAAAA5555 to address 0x80, then read 0x80. Required: each completes with MRdy at edge k+1; the read returns 0x00000000.
